// File: rtl/dmem_bridge.sv
// Data-memory access unit: turns one core load/store into a single aligned
// valid/ready word transaction, with misalignment and bus-timeout faults.
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpuReq,
    input  logic        cpuWe,
    input  logic [31:0] cpuAddr,
    input  logic [31:0] cpuWData,
    input  logic [1:0]  storeCtrl,
    input  logic [2:0]  loadCtrl,
    output logic        cpuStall,
    output logic [31:0] cpuRData,
    output logic        cpuFault,
    output logic        busValid,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [31:0] busWData,
    output logic [3:0]  busBe,
    input  logic        busReady,
    input  logic [31:0] busRData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        bus_valid_q, bus_valid_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [3:0]  bus_be_q, bus_be_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  load_ctrl_q, load_ctrl_d;
    logic [31:0] rdata_q, rdata_d;
    logic        fault_q, fault_d;

    logic [1:0]  size;
    logic        legal;
    logic        aligned;
    logic [3:0]  be_req;
    logic [31:0] wdata_req;
    logic [31:0] shifted;
    logic [31:0] load_data;

    // Request decode: size code is shared between store and load encodings
    always_comb begin
        size      = cpuWe ? storeCtrl : loadCtrl[1:0];
        legal     = 1'b0;
        aligned   = 1'b0;
        be_req    = '0;
        wdata_req = '0;
        if (cpuWe) begin
            legal = (storeCtrl != 2'b11);
        end else begin
            case (loadCtrl)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                default:                                legal = 1'b0;
            endcase
        end
        case (size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = ~cpuAddr[0];
            2'b10:   aligned = (cpuAddr[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase
        if (cpuWe) begin
            case (storeCtrl)
                2'b00: begin
                    be_req    = 4'b0001 << cpuAddr[1:0];
                    wdata_req = {4{cpuWData[7:0]}};
                end
                2'b01: begin
                    be_req    = 4'b0011 << cpuAddr[1:0];
                    wdata_req = {2{cpuWData[15:0]}};
                end
                2'b10: begin
                    be_req    = 4'b1111;
                    wdata_req = cpuWData;
                end
                default: begin
                    be_req    = '0;
                    wdata_req = '0;
                end
            endcase
        end
    end

    always_comb begin
        shifted = busRData >> {off_q, 3'b000};
        case (load_ctrl_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = shifted;
            3'b100:  load_data = {24'b0, shifted[7:0]};
            3'b101:  load_data = {16'b0, shifted[15:0]};
            default: load_data = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_be_d    = bus_be_q;
        off_d       = off_q;
        load_ctrl_d = load_ctrl_q;
        rdata_d     = rdata_q;
        fault_d     = fault_q;
        case (state_q)
            IDLE: begin
                if (cpuReq) begin
                    if (legal && aligned) begin
                        bus_valid_d = 1'b1;
                        bus_we_d    = cpuWe;
                        bus_addr_d  = {cpuAddr[31:2], 2'b00};
                        bus_wdata_d = wdata_req;
                        bus_be_d    = be_req;
                        off_d       = cpuAddr[1:0];
                        load_ctrl_d = loadCtrl;
                        cnt_d       = '0;
                        state_d     = BUS;
                    end else begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end
                end
            end
            BUS: begin
                // A ready in the last permitted cycle still completes normally
                if (busReady) begin
                    bus_valid_d = 1'b0;
                    rdata_d     = bus_we_q ? '0 : load_data;
                    fault_d     = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    bus_valid_d = 1'b0;
                    rdata_d     = '0;
                    fault_d     = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            RESP: begin
                rdata_d = '0;
                fault_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_be_q    <= '0;
            off_q       <= '0;
            load_ctrl_q <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_be_q    <= bus_be_d;
            off_q       <= off_d;
            load_ctrl_q <= load_ctrl_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    assign cpuStall = cpuReq & (state_q != RESP);
    assign cpuRData = rdata_q;
    assign cpuFault = fault_q;
    assign busValid = bus_valid_q;
    assign busWe    = bus_we_q;
    assign busAddr  = bus_addr_q;
    assign busWData = bus_wdata_q;
    assign busBe    = bus_be_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed bench for dmem_bridge with TIMEOUT=4; inputs change 1ns after the
// rising edge and outputs are sampled after they settle.
module tb_dmem_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpuReq;
    logic        cpuWe;
    logic [31:0] cpuAddr;
    logic [31:0] cpuWData;
    logic [1:0]  storeCtrl;
    logic [2:0]  loadCtrl;
    logic        cpuStall;
    logic [31:0] cpuRData;
    logic        cpuFault;
    logic        busValid;
    logic        busWe;
    logic [31:0] busAddr;
    logic [31:0] busWData;
    logic [3:0]  busBe;
    logic        busReady;
    logic [31:0] busRData;

    int tests_run = 0;
    int fails     = 0;

    dmem_bridge #(.TIMEOUT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .cpuReq   (cpuReq),
        .cpuWe    (cpuWe),
        .cpuAddr  (cpuAddr),
        .cpuWData (cpuWData),
        .storeCtrl(storeCtrl),
        .loadCtrl (loadCtrl),
        .cpuStall (cpuStall),
        .cpuRData (cpuRData),
        .cpuFault (cpuFault),
        .busValid (busValid),
        .busWe    (busWe),
        .busAddr  (busAddr),
        .busWData (busWData),
        .busBe    (busBe),
        .busReady (busReady),
        .busRData (busRData)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] sc, input logic [2:0] lc);
        cpuWe     = we;
        cpuAddr   = a;
        cpuWData  = d;
        storeCtrl = sc;
        loadCtrl  = lc;
        cpuReq    = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWData = '0;
        storeCtrl = '0; loadCtrl = '0; busReady = 1'b0; busRData = '0;
        #3;
        tests_run++; if (busValid !== 1'b0) begin fails++; $display("FAIL reset_busValid got=%b exp=0", busValid); end
        tests_run++; if (busWe !== 1'b0) begin fails++; $display("FAIL reset_busWe got=%b exp=0", busWe); end
        tests_run++; if (busAddr !== 32'h0) begin fails++; $display("FAIL reset_busAddr got=%h exp=0", busAddr); end
        tests_run++; if (busWData !== 32'h0) begin fails++; $display("FAIL reset_busWData got=%h exp=0", busWData); end
        tests_run++; if (busBe !== 4'h0) begin fails++; $display("FAIL reset_busBe got=%b exp=0000", busBe); end
        tests_run++; if (cpuRData !== 32'h0) begin fails++; $display("FAIL reset_cpuRData got=%h exp=0", cpuRData); end
        tests_run++; if (cpuFault !== 1'b0) begin fails++; $display("FAIL reset_cpuFault got=%b exp=0", cpuFault); end
        tests_run++; if (cpuStall !== 1'b0) begin fails++; $display("FAIL reset_stall_idle got=%b exp=0", cpuStall); end
        cpuReq = 1'b1; #1;
        tests_run++; if (cpuStall !== 1'b1) begin fails++; $display("FAIL reset_stall_follows_req got=%b exp=1", cpuStall); end
        cpuReq = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_word_store();
        busReady = 1'b1;
        issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 3'b010);
        tests_run++; if (cpuStall !== 1'b1) begin fails++; $display("FAIL sw_stall_c0 got=%b exp=1", cpuStall); end
        tests_run++; if (busValid !== 1'b0) begin fails++; $display("FAIL sw_valid_c0 got=%b exp=0", busValid); end
        cyc();
        tests_run++; if (busValid !== 1'b1) begin fails++; $display("FAIL sw_valid_c1 got=%b exp=1", busValid); end
        tests_run++; if (busWe !== 1'b1) begin fails++; $display("FAIL sw_we got=%b exp=1", busWe); end
        tests_run++; if (busAddr !== 32'h0000_0100) begin fails++; $display("FAIL sw_addr got=%h exp=00000100", busAddr); end
        tests_run++; if (busBe !== 4'b1111) begin fails++; $display("FAIL sw_be got=%b exp=1111", busBe); end
        tests_run++; if (busWData !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sw_wdata got=%h exp=deadbeef", busWData); end
        tests_run++; if (cpuStall !== 1'b1) begin fails++; $display("FAIL sw_stall_c1 got=%b exp=1", cpuStall); end
        cyc();
        tests_run++; if (busValid !== 1'b0) begin fails++; $display("FAIL sw_valid_resp got=%b exp=0", busValid); end
        tests_run++; if (cpuStall !== 1'b0) begin fails++; $display("FAIL sw_stall_resp got=%b exp=0", cpuStall); end
        tests_run++; if (cpuFault !== 1'b0) begin fails++; $display("FAIL sw_fault got=%b exp=0", cpuFault); end
        tests_run++; if (cpuRData !== 32'h0) begin fails++; $display("FAIL sw_rdata got=%h exp=0", cpuRData); end
        cyc();
        cpuReq = 1'b0;
        tests_run++; if (busValid !== 1'b0) begin fails++; $display("FAIL sw_no_reissue got=%b exp=0", busValid); end
        cyc();
    endtask

    task automatic test_byte_load();
        logic [2:0]  lcs [2] = '{3'b000, 3'b100};
        logic [31:0] exps[2] = '{32'hFFFF_FF80, 32'h0000_0080};
        busReady = 1'b1;
        busRData = 32'h80FF_1234;
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 32'h0000_0203, 32'h0, 2'b00, lcs[i]);
            cyc();
            tests_run++; if (busValid !== 1'b1) begin fails++; $display("FAIL lb%0d_valid got=%b exp=1", i, busValid); end
            tests_run++; if (busAddr !== 32'h0000_0200) begin fails++; $display("FAIL lb%0d_addr got=%h exp=00000200", i, busAddr); end
            tests_run++; if (busBe !== 4'b0000) begin fails++; $display("FAIL lb%0d_be got=%b exp=0000", i, busBe); end
            tests_run++; if (busWe !== 1'b0) begin fails++; $display("FAIL lb%0d_we got=%b exp=0", i, busWe); end
            cyc();
            tests_run++; if (cpuRData !== exps[i]) begin fails++; $display("FAIL lb%0d_rdata got=%h exp=%h", i, cpuRData, exps[i]); end
            tests_run++; if (cpuFault !== 1'b0) begin fails++; $display("FAIL lb%0d_fault got=%b exp=0", i, cpuFault); end
            cyc();
            cpuReq = 1'b0;
            cyc();
        end
    endtask

    task automatic test_half();
        logic [2:0]  lcs [2] = '{3'b101, 3'b001};
        logic [31:0] exps[2] = '{32'h0000_ABCD, 32'hFFFF_ABCD};
        busReady = 1'b1;
        issue(1'b1, 32'h0000_0302, 32'h0000_ABCD, 2'b01, 3'b000);
        cyc();
        tests_run++; if (busAddr !== 32'h0000_0300) begin fails++; $display("FAIL sh_addr got=%h exp=00000300", busAddr); end
        tests_run++; if (busBe !== 4'b1100) begin fails++; $display("FAIL sh_be got=%b exp=1100", busBe); end
        tests_run++; if (busWData !== 32'hABCD_ABCD) begin fails++; $display("FAIL sh_wdata got=%h exp=abcdabcd", busWData); end
        cyc();
        tests_run++; if (cpuFault !== 1'b0) begin fails++; $display("FAIL sh_fault got=%b exp=0", cpuFault); end
        cyc();
        cpuReq = 1'b0;
        cyc();
        busRData = 32'hABCD_0000;
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 32'h0000_0302, 32'h0, 2'b00, lcs[i]);
            cyc(); cyc();
            tests_run++; if (cpuRData !== exps[i]) begin fails++; $display("FAIL lh%0d_rdata got=%h exp=%h", i, cpuRData, exps[i]); end
            cyc();
            cpuReq = 1'b0;
            cyc();
        end
    endtask

    task automatic test_misaligned();
        logic        wes [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] adrs[4] = '{32'h101, 32'h100, 32'h103, 32'h100};
        logic [1:0]  scs [4] = '{2'b00, 2'b11, 2'b00, 2'b00};
        logic [2:0]  lcs [4] = '{3'b010, 3'b000, 3'b001, 3'b011};
        busReady = 1'b1;
        busRData = 32'h5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            issue(wes[i], adrs[i], 32'h1234_5678, scs[i], lcs[i]);
            tests_run++; if (cpuStall !== 1'b1) begin fails++; $display("FAIL mis%0d_stall_c0 got=%b exp=1", i, cpuStall); end
            cyc();
            tests_run++; if (busValid !== 1'b0) begin fails++; $display("FAIL mis%0d_valid got=%b exp=0", i, busValid); end
            tests_run++; if (cpuStall !== 1'b0) begin fails++; $display("FAIL mis%0d_stall_resp got=%b exp=0", i, cpuStall); end
            tests_run++; if (cpuFault !== 1'b1) begin fails++; $display("FAIL mis%0d_fault got=%b exp=1", i, cpuFault); end
            tests_run++; if (cpuRData !== 32'h0) begin fails++; $display("FAIL mis%0d_rdata got=%h exp=0", i, cpuRData); end
            cyc();
            cpuReq = 1'b0;
            tests_run++; if (busValid !== 1'b0) begin fails++; $display("FAIL mis%0d_valid_after got=%b exp=0", i, busValid); end
            tests_run++; if (cpuFault !== 1'b0) begin fails++; $display("FAIL mis%0d_fault_after got=%b exp=0", i, cpuFault); end
            cyc();
        end
    endtask

    task automatic test_wait_states();
        int stalls = 0;
        busReady = 1'b0;
        busRData = 32'h1234_5678;
        issue(1'b0, 32'h0000_0400, 32'h0, 2'b00, 3'b010);
        for (int c = 0; c < 20 && cpuStall; c++) begin
            stalls++;
            if (c >= 1) begin
                tests_run++; if (busValid !== 1'b1) begin fails++; $display("FAIL ws_valid_c%0d got=%b exp=1", c, busValid); end
                tests_run++; if (busAddr !== 32'h0000_0400) begin fails++; $display("FAIL ws_addr_c%0d got=%h exp=00000400", c, busAddr); end
                tests_run++; if (busWe !== 1'b0 || busBe !== 4'b0000) begin fails++; $display("FAIL ws_ctrl_c%0d got=%b/%b exp=0/0000", c, busWe, busBe); end
            end
            if (c == 1) begin
                cpuAddr = 32'hFFFF_FFFC;
                cpuWe   = 1'b1;
            end
            cyc();
            if (c + 1 == 4) busReady = 1'b1;
        end
        tests_run++; if (stalls !== 5) begin fails++; $display("FAIL ws_stall_cycles got=%0d exp=5", stalls); end
        tests_run++; if (cpuRData !== 32'h1234_5678) begin fails++; $display("FAIL ws_rdata got=%h exp=12345678", cpuRData); end
        tests_run++; if (cpuFault !== 1'b0) begin fails++; $display("FAIL ws_fault got=%b exp=0", cpuFault); end
        cyc();
        cpuReq = 1'b0;
        busReady = 1'b0;
        cyc();
    endtask

    task automatic test_timeout();
        int nvalid = 0;
        int stalls = 0;
        busReady = 1'b0;
        issue(1'b1, 32'h0000_0500, 32'h1122_3344, 2'b10, 3'b000);
        for (int c = 0; c < 20 && cpuStall; c++) begin
            stalls++;
            if (busValid) nvalid++;
            cyc();
        end
        tests_run++; if (nvalid !== 4) begin fails++; $display("FAIL to_valid_cycles got=%0d exp=4", nvalid); end
        tests_run++; if (stalls !== 5) begin fails++; $display("FAIL to_stall_cycles got=%0d exp=5", stalls); end
        tests_run++; if (cpuFault !== 1'b1) begin fails++; $display("FAIL to_fault got=%b exp=1", cpuFault); end
        tests_run++; if (cpuRData !== 32'h0) begin fails++; $display("FAIL to_rdata got=%h exp=0", cpuRData); end
        tests_run++; if (busValid !== 1'b0) begin fails++; $display("FAIL to_valid_resp got=%b exp=0", busValid); end
        cyc();
        cpuReq = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid_access();
        busReady = 1'b0;
        issue(1'b0, 32'h0000_0600, 32'h0, 2'b00, 3'b010);
        cyc();
        tests_run++; if (busValid !== 1'b1) begin fails++; $display("FAIL rm_valid_bus got=%b exp=1", busValid); end
        #2 rst = 1'b1;
        #1;
        tests_run++; if (busValid !== 1'b0) begin fails++; $display("FAIL rm_valid_async got=%b exp=0", busValid); end
        tests_run++; if (busAddr !== 32'h0) begin fails++; $display("FAIL rm_addr_async got=%h exp=0", busAddr); end
        cpuReq = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        tests_run++; if (cpuFault !== 1'b0 || busValid !== 1'b0) begin fails++; $display("FAIL rm_no_resp got=%b/%b exp=0/0", cpuFault, busValid); end
        busReady = 1'b1;
        busRData = 32'hCAFE_F00D;
        issue(1'b0, 32'h0000_0604, 32'h0, 2'b00, 3'b010);
        cyc();
        tests_run++; if (busValid !== 1'b1 || busAddr !== 32'h0000_0604) begin fails++; $display("FAIL rm_new_bus got=%b/%h exp=1/00000604", busValid, busAddr); end
        cyc();
        tests_run++; if (cpuRData !== 32'hCAFE_F00D) begin fails++; $display("FAIL rm_new_rdata got=%h exp=cafef00d", cpuRData); end
        tests_run++; if (cpuStall !== 1'b0 || cpuFault !== 1'b0) begin fails++; $display("FAIL rm_new_resp got=%b/%b exp=0/0", cpuStall, cpuFault); end
        cyc();
        cpuReq = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_half();
        test_misaligned();
        test_wait_states();
        test_timeout();
        test_reset_mid_access();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=time_limit exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_bridge.md
# dmem_bridge

Data-memory access unit between the core's load/store datapath and a word-wide valid/ready memory bus. It takes the core's load/store request (address, store data, size/sign controls) and stalls the core until the access completes. On the bus side it issues one aligned word transaction with byte enables. On the core side it returns sign- or zero-extended load data. It converts misaligned accesses and bus timeouts into a fault instead of a bus transaction or a hang.

## Interface
Parameters:
- TIMEOUT, default 255: number of cycles with busValid=1 and busReady=0 before the access is abandoned; range 1..1023.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- cpuReq  in  1  core requests a load or store. Held stable while cpuStall=1.
- cpuWe  in  1  1=store, 0=load.
- cpuAddr  in  32  byte address.
- cpuWData  in  32  store data, right-justified.
- storeCtrl  in  2  store size: 00 byte, 01 half, 10 word. 11 is illegal.
- loadCtrl  in  3  load type, RISC-V funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Other codes are illegal.
- cpuStall  out  1  freeze the core.
- cpuRData  out  32  extended load data. Valid only in the RESP cycle.
- cpuFault  out  1  access fault. High only in the RESP cycle.
- busValid  out  1  bus request.
- busWe  out  1  bus write.
- busAddr  out  32  word address; bits [1:0] are always 00.
- busWData  out  32  lane-replicated store data.
- busBe  out  4  byte enables. 0000 for loads.
- busReady  in  1  slave accepts the request. For loads, busRData is valid in the same cycle.
- busRData  in  32  read word.

## Operation
- FSM states: IDLE, BUS, RESP.
- cpuStall = cpuReq & (state != RESP). Combinational.
- IDLE, cpuReq=0: remain in IDLE.
- IDLE, cpuReq=1, legal and aligned: register bus outputs, set busValid=1, go to BUS.
- IDLE, cpuReq=1, misaligned or illegal code: go to RESP with fault flag set. No bus transaction occurs and no store is performed.
- Alignment rules: half requires addr[0]=0; word requires addr[1:0]=00; byte accesses are always aligned.
- BUS, busReady=1: capture busRData (loads), clear busValid, go to RESP.
- BUS, busReady=0: increment the timeout counter. When the counter reaches TIMEOUT-1, clear busValid, set the fault flag, and go to RESP.
- RESP: cpuStall=0 and cpuFault=flag. cpuRData holds the extended load data, or 0 on a fault or a store. Always go to IDLE next cycle.
- Byte enables:
  - byte: 0001 << addr[1:0]
  - half: 0011 << addr[1:0]
  - word: 1111
- busWData:
  - byte: {4{cpuWData[7:0]}}
  - half: {2{cpuWData[15:0]}}
  - word: cpuWData
- Load extract: the lane is selected by addr[1:0], shifted right by 8*addr[1:0], then sign- or zero-extended per loadCtrl.
- Address and controls are registered at IDLE exit. Later changes on the cpu inputs during BUS have no effect.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE and counter=0.
  - busValid, busWe, busAddr, busWData, busBe, cpuRData and cpuFault all 0.
  - cpuStall follows cpuReq.
- Reset during BUS drops busValid immediately. No RESP cycle follows.
- Zero-wait access: request seen in cycle 0 (IDLE), busValid=1 in cycle 1 with busReady=1, RESP in cycle 2. cpuStall is high in cycles 0 and 1. Core latency is 3 cycles.
- Each wait cycle adds 1 cycle of latency.
- Bus outputs are registered and stay stable while busValid=1 and busReady=0.
- Fault latency: a misaligned request reaches RESP 1 cycle after IDLE (stall high for 1 cycle). A timeout reaches RESP exactly TIMEOUT cycles after busValid rises.
- The core advances at the RESP edge. The IDLE cycle that follows belongs to the next instruction's request, so the completed request is never re-issued.
- There is at most one outstanding bus transaction.

## Test plan
- Word store: addr 0x100, data 0xDEADBEEF, storeCtrl 10, busReady tied 1. Required: one bus cycle with busAddr 0x100, busBe 1111, busWData 0xDEADBEEF; stall for 2 cycles; cpuFault=0.
- Byte load, sign-extended: lb at 0x203, busRData 0x80FF_1234. Required: busAddr 0x200, busBe 0000, cpuRData 0xFFFFFF80 in RESP. The same access as lbu gives 0x00000080.
- Halfword store: sh at 0x302, data 0x0000ABCD. Required: busBe 1100, busWData 0xABCDABCD. The matching lhu read of busRData 0xABCD0000 gives 0x0000ABCD.
- Misaligned: lw at 0x101. Required: busValid never rises, RESP in the next cycle with cpuFault=1 and cpuRData 0. Same requirement for storeCtrl=11.
- Wait states and timeout: busReady held low for 3 cycles then high. Required: bus outputs stable, stall for 5 cycles. With busReady held low and TIMEOUT=4: busValid high for 4 cycles, then RESP with cpuFault=1.
- Reset mid-access: assert rst during BUS. Required: busValid=0 immediately and state IDLE. After release, a new request completes normally.
